fp_pack_round: RTL and testbench
================================

// Module: fp_pack_round
// PURPOSE
//  Result back end of the FPU: the output-side counterpart of operand classification. Takes an
//  unnormalised sign/exponent/mantissa from the arithmetic core plus the 2-bit special-case flag,
//  normalises it iteratively (1 bit/cycle), rounds to nearest-even and packs an IEEE-754 single.
//  Sits between the add/mul datapath and the FPU result register; valid/ready on both sides.
// PARAMETERS
//  EXP_W     10            width of signed (two's complement) biased exponent input, bias 127
//  CANON_NAN 32'h7FC00000  word emitted for every NaN result
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      input beat valid
//  in_ready     out  1      block idle, accepts a beat
//  in_sign      in   1      result sign
//  in_exp       in   EXP_W  signed biased exponent of mantissa bit 26
//  in_mant      in   28     [27]=carry [26]=hidden [25:3]=fraction [2]=guard [1]=round [0]=sticky
//  in_flag      in   2      00 normal, 01 zero, 10 infinity, 11 NaN
//  out_valid    out  1      result valid, held until out_ready
//  out_ready    in   1      downstream accepts result
//  out_result   out  32     packed IEEE-754 single
//  out_overflow out  1      finite input rounded to infinity
//  out_underflow out 1      result tiny (denormal/zero) and inexact
//  out_inexact  out  1      G|R|S nonzero at rounding
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_result=0, all status flags 0. rst mid-
//    operation discards the beat; in_ready=1 on the cycle after rst deasserts. rst beats in_valid.
//  - FSM IDLE->NORM->ROUND->DONE->IDLE. Accept iff in_valid&&in_ready (in_ready=1 only in IDLE).
//  - IDLE accept: in_flag!=00 or in_mant==0 -> go straight to DONE with special word:
//    11 -> CANON_NAN (sign ignored); 10 -> {sign,8'hFF,23'h0}; 01 or mant==0 -> {sign,31'h0}.
//  - NORM, one action per cycle, priority order:
//    1) mant[27]=1: mant>>=1 with bit0 |= shifted-out bit, exp+=1.
//    2) exp < -25: mant={27'h0,|mant}, exp=1 (single-cycle flush, bounds latency).
//    3) exp < 1: mant>>=1 sticky-preserving, exp+=1 (denormal alignment).
//    4) mant[26]=0 and exp>1: mant<<=1, exp-=1.
//    5) else (mant[26]=1, or exp==1 denormal) -> ROUND.
//  - ROUND (1 cycle): up = G&(R|S|L), L=mant[3]; mant += up<<3; carry into bit27 -> mant>>=1,
//    exp+=1. Then: exp>=255 -> {sign,8'hFF,23'h0}, out_overflow=1. Else exp field = mant[26] ?
//    exp[7:0] : 8'h00 (denormal rounding up to bit26 becomes exp field 1), frac = mant[25:3].
//    out_inexact=|mant[2:0] pre-round; out_underflow = inexact & (mant[26]==0 pre-round).
//  - Latency: special/zero: out_valid on cycle T+1 after accept edge T; already-normalised
//    input: T+3; each NORM shift adds 1 cycle. Worst case bounded by rule 2 (< 40 cycles).
//  - DONE: out_valid=1, outputs stable; out_valid&&out_ready -> IDLE next cycle, out_valid=0.
//    No new beat accepted while DONE (no bypass, one beat in flight).
//  - Status flags are 0 for special (flag!=00) results. Exponent arithmetic in EXP_W+1 bits; no wrap.
// TESTING
//  1. flag=00, sign0, exp=127, mant=1<<26 -> 32'h3F800000, out_valid 3 cycles after accept,
//     inexact=0.
//  2. exp=127, mant=28'h7FFFFFC (G=1,L=1) -> round-carry, 32'h40000000, out_inexact=1.
//  3. exp=130, mant=1<<23 -> three left shifts, 32'h3F800000 at T+6; exp=0, mant=1<<26 ->
//     32'h00400000, underflow=0.
//  4. exp=254, mant=1<<27 -> 32'h7F800000, out_overflow=1; exp=-100, mant=1 -> 32'h00000000,
//     underflow=1.
//  5. flag=11 sign1 -> 32'h7FC00000; flag=10 sign1 -> 32'hFF800000; flag=01 sign1 -> 32'h80000000,
//     each at T+1.
//  6. out_ready=0 for 5 cycles -> out_result stable, in_ready=0; rst pulsed in NORM -> out_valid=0,
//     in_ready=1 next cycle, next beat processed normally.

Source files
------------

// File: rtl/fp_pack_round.sv
// Floating-point result back end: normalises an unnormalised sign/exponent/mantissa
// one bit per cycle, rounds to nearest-even and packs an IEEE-754 single.
// Special-case flags (zero/inf/NaN) bypass normalisation and produce fixed words.
module fp_pack_round #(
    parameter int          EXP_W     = 10,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [27:0]      in_mant,
    input  logic [1:0]       in_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    // One extra bit so exponent increments/decrements can never wrap.
    localparam int XW = EXP_W + 1;
    localparam logic signed [XW-1:0] EXP_FLUSH = XW'(-32'sd25);
    localparam logic signed [XW-1:0] EXP_ONE   = XW'(32'sd1);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'(32'sd255);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r, state_nx_s;
    logic                   sign_r, sign_nx_s;
    logic signed [XW-1:0]   exp_r, exp_nx_s;
    logic [27:0]            mant_r, mant_nx_s;
    logic [31:0]            result_r, result_nx_s;
    logic                   ovf_r, ovf_nx_s;
    logic                   unf_r, unf_nx_s;
    logic                   inx_r, inx_nx_s;
    logic                   in_ready_r;
    logic                   out_valid_r;

    logic                   accept_s;
    logic signed [XW-1:0]   in_exp_ext_s;
    logic                   round_up_s;
    logic [27:0]            sum_s;
    logic [27:0]            mant_rnd_s;
    logic signed [XW-1:0]   exp_rnd_s;

    assign accept_s     = in_valid && in_ready_r;
    assign in_exp_ext_s = $signed({in_exp[EXP_W-1], in_exp});

    // Round-to-nearest-even on the normalised mantissa, renormalising a carry-out.
    always_comb begin
        round_up_s = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
        sum_s      = mant_r + {24'h000000, round_up_s, 3'b000};
        if (sum_s[27]) begin
            mant_rnd_s = {1'b0, sum_s[27:1]};
            exp_rnd_s  = exp_r + EXP_ONE;
        end else begin
            mant_rnd_s = sum_s;
            exp_rnd_s  = exp_r;
        end
    end

    // Next-state and datapath update for the IDLE/NORM/ROUND/DONE sequence.
    always_comb begin
        state_nx_s  = state_r;
        sign_nx_s   = sign_r;
        exp_nx_s    = exp_r;
        mant_nx_s   = mant_r;
        result_nx_s = result_r;
        ovf_nx_s    = ovf_r;
        unf_nx_s    = unf_r;
        inx_nx_s    = inx_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sign_nx_s = in_sign;
                    exp_nx_s  = in_exp_ext_s;
                    mant_nx_s = in_mant;
                    ovf_nx_s  = 1'b0;
                    unf_nx_s  = 1'b0;
                    inx_nx_s  = 1'b0;
                    if ((in_flag != 2'b00) || (in_mant == 28'h0000000)) begin
                        state_nx_s = DONE;
                        case (in_flag)
                            2'b11:   result_nx_s = CANON_NAN;
                            2'b10:   result_nx_s = {in_sign, 8'hFF, 23'h000000};
                            default: result_nx_s = {in_sign, 31'h00000000};
                        endcase
                    end else begin
                        state_nx_s = NORM;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            NORM: begin
                if (mant_r[27]) begin
                    // Carry out of the core: shift right keeping the sticky bit.
                    mant_nx_s = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                    exp_nx_s  = exp_r + EXP_ONE;
                end else if (exp_r < EXP_FLUSH) begin
                    // Far below the denormal range: collapse to sticky in one step.
                    mant_nx_s = {27'h0000000, |mant_r};
                    exp_nx_s  = EXP_ONE;
                end else if (exp_r < EXP_ONE) begin
                    // Denormal alignment toward exponent 1.
                    mant_nx_s = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                    exp_nx_s  = exp_r + EXP_ONE;
                end else if (!mant_r[26] && (exp_r > EXP_ONE)) begin
                    mant_nx_s = {mant_r[26:0], 1'b0};
                    exp_nx_s  = exp_r - EXP_ONE;
                end else begin
                    state_nx_s = ROUND;
                end
            end
            ROUND: begin
                state_nx_s = DONE;
                inx_nx_s   = |mant_r[2:0];
                unf_nx_s   = (|mant_r[2:0]) & ~mant_r[26];
                if (exp_rnd_s >= EXP_MAX) begin
                    result_nx_s = {sign_r, 8'hFF, 23'h000000};
                    ovf_nx_s    = 1'b1;
                end else begin
                    // A denormal that rounds up into bit 26 picks up exponent field 1.
                    result_nx_s = {sign_r, (mant_rnd_s[26] ? exp_rnd_s[7:0] : 8'h00),
                                   mant_rnd_s[25:3]};
                    ovf_nx_s    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            mant_r      <= 28'h0000000;
            result_r    <= 32'h00000000;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            inx_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            sign_r      <= sign_nx_s;
            exp_r       <= exp_nx_s;
            mant_r      <= mant_nx_s;
            result_r    <= result_nx_s;
            ovf_r       <= ovf_nx_s;
            unf_r       <= unf_nx_s;
            inx_r       <= inx_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_result    = result_r;
    assign out_overflow  = ovf_r;
    assign out_underflow = unf_r;
    assign out_inexact   = inx_r;

endmodule

// File: tb/tb_fp_pack_round.sv
// Scoreboard bench for fp_pack_round: driver pushes expected results, a
// negedge monitor compares whenever the DUT presents a result.
module tb_fp_pack_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = 10'h000;
    logic [27:0] in_mant = 28'h0;
    logic [1:0]  in_flag = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    bit   seen = 1'b0;

    fp_pack_round #(.EXP_W(10), .CANON_NAN(32'h7FC00000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_flag(in_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endfunction

    // Monitor: check first valid cycle fully, stall cycles for stability, pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    chk({sb[0].nm, "_lat"}, cyc - sb[0].acc + 1, sb[0].lat);
                    chk({sb[0].nm, "_res"}, out_result, sb[0].res);
                    chk({sb[0].nm, "_ovf"}, {31'h0, out_overflow}, {31'h0, sb[0].ovf});
                    chk({sb[0].nm, "_unf"}, {31'h0, out_underflow}, {31'h0, sb[0].unf});
                    chk({sb[0].nm, "_inx"}, {31'h0, out_inexact}, {31'h0, sb[0].inx});
                    seen = 1'b1;
                end else begin
                    chk({sb[0].nm, "_hold_res"}, out_result, sb[0].res);
                    chk({sb[0].nm, "_hold_inrdy"}, {31'h0, in_ready}, 32'h0);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(string nm, logic s, logic [9:0] e, logic [27:0] m, logic [1:0] f,
                        logic [31:0] res, logic ovf, logic unf, logic inx, int lat);
        exp_t x;
        wait_ready();
        x.nm = nm; x.res = res; x.ovf = ovf; x.unf = unf; x.inx = inx;
        x.lat = lat; x.acc = cyc + 1;
        sb.push_back(x);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_flag = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_result", out_result, 32'h0);
        chk("rst_flags", {29'h0, out_overflow, out_underflow, out_inexact}, 32'h0);

        //            name        s     exp      mant          flag   result         ovf   unf   inx  lat
        send("one",       1'b0, 10'd127, 28'h4000000, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3);
        send("rndcarry",  1'b0, 10'd127, 28'h7FFFFFC, 2'b00, 32'h40000000, 1'b0, 1'b0, 1'b1, 3);
        send("lshift3",   1'b0, 10'd130, 28'h0800000, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0, 6);
        send("denorm",    1'b0, 10'd0,   28'h4000000, 2'b00, 32'h00400000, 1'b0, 1'b0, 1'b0, 4);
        send("ovf",       1'b0, 10'd254, 28'h8000000, 2'b00, 32'h7F800000, 1'b1, 1'b0, 1'b0, 4);
        send("flush",     1'b0, 10'h39C, 28'h0000001, 2'b00, 32'h00000000, 1'b0, 1'b1, 1'b1, 4);
        send("nan",       1'b1, 10'd5,   28'h4000000, 2'b11, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 1);
        send("inf",       1'b1, 10'd5,   28'h4000000, 2'b10, 32'hFF800000, 1'b0, 1'b0, 1'b0, 1);
        send("zero",      1'b1, 10'd5,   28'h4000000, 2'b01, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);
        send("zmant",     1'b1, 10'd127, 28'h0000000, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);
        send("neg3",      1'b1, 10'd128, 28'h6000000, 2'b00, 32'hC0400000, 1'b0, 1'b0, 1'b0, 3);
        send("tie_even",  1'b0, 10'd127, 28'h4000004, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b1, 3);
        send("tie_odd",   1'b0, 10'd127, 28'h400000C, 2'b00, 32'h3F800002, 1'b0, 1'b0, 1'b1, 3);
        send("dn2norm",   1'b0, 10'd1,   28'h3FFFFFC, 2'b00, 32'h00800000, 1'b0, 1'b1, 1'b1, 3);
        send("rndovf",    1'b0, 10'd254, 28'h7FFFFFC, 2'b00, 32'h7F800000, 1'b1, 1'b0, 1'b1, 3);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send("stall",     1'b0, 10'd127, 28'h4000000, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3);
        repeat (7) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        drain();

        // Reset in the middle of normalisation discards the beat.
        wait_ready();
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd130; in_mant = 28'h0800000; in_flag = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (8) begin @(posedge clk); #1; end
        chk("midrst_quiet", {31'h0, out_valid}, 32'h0);
        send("after_rst", 1'b0, 10'd127, 28'h4000000, 2'b00, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
